// File: rtl/spi_pkg.sv
// Shared definitions for the SPI command receiver and its downstream decoder:
// FSM state type, the long-command flag bit and the SUMP opcode constants.
package spi_pkg;

    // Command parser states
    typedef enum logic [1:0] {
        READOPCODE = 2'd0,
        READLONG   = 2'd1,
        EXECUTE    = 2'd2
    } rx_state_e;

    // Opcode bit that marks a 5-byte command (opcode + 4 argument bytes)
    localparam int LONG_CMD_BIT = 7;

    // SUMP opcodes understood by the command decoder
    localparam logic [7:0] OP_RESET        = 8'h00;
    localparam logic [7:0] OP_RUN          = 8'h01;
    localparam logic [7:0] OP_QUERY_ID     = 8'h02;
    localparam logic [7:0] OP_QUERY_META   = 8'h04;
    localparam logic [7:0] OP_TRIGGER_MASK = 8'hC0;

endpackage

// File: rtl/spi_rx_sync.sv
// Input conditioning for the SPI slave: identical 2-flop synchronizers on
// sclk, cs and rx so the three stay aligned, plus a third sclk flop for
// rising-edge detection.
module spi_rx_sync (
    input  logic clock,
    input  logic extReset,
    input  logic sclk,
    input  logic cs,
    input  logic rx,
    output logic cs_sync,
    output logic rx_sync,
    output logic sclk_rise
);

    logic sclk_meta_q, sclk_meta_d;
    logic sclk_sync_q, sclk_sync_d;
    logic sclk_dly_q,  sclk_dly_d;
    logic cs_meta_q,   cs_meta_d;
    logic cs_sync_q,   cs_sync_d;
    logic rx_meta_q,   rx_meta_d;
    logic rx_sync_q,   rx_sync_d;

    // Next-state of every synchronizer stage is simply the previous stage
    always_comb begin
        sclk_meta_d = sclk;
        sclk_sync_d = sclk_meta_q;
        sclk_dly_d  = sclk_sync_q;
        cs_meta_d   = cs;
        cs_sync_d   = cs_meta_q;
        rx_meta_d   = rx;
        rx_sync_d   = rx_meta_q;
    end

    // Synchronizer flops; reset to the idle bus state (sclk low, cs high)
    always_ff @(posedge clock or posedge extReset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (extReset) begin
            sclk_meta_q <= 1'b0;
            sclk_sync_q <= 1'b0;
            sclk_dly_q  <= 1'b0;
            cs_meta_q   <= 1'b1;
            cs_sync_q   <= 1'b1;
            rx_meta_q   <= 1'b0;
            rx_sync_q   <= 1'b0;
        end else begin
            sclk_meta_q <= sclk_meta_d;
            sclk_sync_q <= sclk_sync_d;
            sclk_dly_q  <= sclk_dly_d;
            cs_meta_q   <= cs_meta_d;
            cs_sync_q   <= cs_sync_d;
            rx_meta_q   <= rx_meta_d;
            rx_sync_q   <= rx_sync_d;
        end
    end

    assign cs_sync   = cs_sync_q;
    assign rx_sync   = rx_sync_q;
    assign sclk_rise = sclk_sync_q & ~sclk_dly_q;

endmodule

// File: rtl/spi_receiver.sv
// SPI slave command receiver: assembles MSB-first bytes from MOSI and parses
// the SUMP stream (1-byte short / 5-byte long commands) into op, data and a
// one-cycle execute strobe.
// Optional feature: define SPI_RX_TIMEOUT_EN to discard partial bytes and
// commands after TIMEOUT_CYCLES idle clocks without an sclk rise.
module spi_receiver
    import spi_pkg::*;
#(
    parameter int unsigned          TIMEOUT_W      = 20,
    parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYCLES = 20'hFFFFF
) (
    input  logic        clock,
    input  logic        extReset,
    input  logic        sclk,
    input  logic        cs,
    input  logic        rx,
    output logic [7:0]  op,
    output logic [31:0] data,
    output logic        execute
);

    logic cs_sync;
    logic rx_sync;
    logic sclk_rise;
    logic timeout_fire;

    spi_rx_sync u_sync (
        .clock     (clock),
        .extReset  (extReset),
        .sclk      (sclk),
        .cs        (cs),
        .rx        (rx),
        .cs_sync   (cs_sync),
        .rx_sync   (rx_sync),
        .sclk_rise (sclk_rise)
    );

`ifdef SPI_RX_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] idle_q, idle_d;

    // Idle counter: cleared by each sclk rise, otherwise counts up and saturates
    always_comb begin
        idle_d = idle_q;
        if (sclk_rise) begin
            idle_d = '0;
        end else if (idle_q != {TIMEOUT_W{1'b1}}) begin
            idle_d = idle_q + 1'b1;
        end
        timeout_fire = !sclk_rise && (idle_q >= TIMEOUT_CYCLES);
    end

    // Idle counter register
    always_ff @(posedge clock or posedge extReset) begin
        if (extReset) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end
`else
    assign timeout_fire = 1'b0;
`endif

    // Bit assembly
    logic [2:0]  bits_q, bits_d;
    logic [7:0]  shift_q, shift_d;
    logic        byte_valid_q, byte_valid_d;
    logic [7:0]  byte_q, byte_d;

    // Command parser
    rx_state_e   state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [7:0]  op_sh_q, op_sh_d;
    logic [31:0] data_sh_q, data_sh_d;
    logic        pend_valid_q, pend_valid_d;
    logic [7:0]  pend_byte_q, pend_byte_d;
    logic [7:0]  op_q, op_d;
    logic [31:0] data_q, data_d;
    logic        execute_q, execute_d;

    logic        in_valid;
    logic [7:0]  in_byte;
    logic [31:0] data_word;

    // Shift in MOSI on each sclk rise; the 8th bit publishes a byte for one cycle
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        bits_d       = bits_q;
        shift_d      = shift_q;
        byte_valid_d = 1'b0;
        byte_d       = byte_q;
        if (cs_sync || timeout_fire) begin
            bits_d  = 3'd0;
            shift_d = 8'h00;
        end else if (sclk_rise) begin
            shift_d = {shift_q[6:0], rx_sync};
            bits_d  = bits_q + 3'd1;
            if (bits_q == 3'd7) begin
                byte_valid_d = 1'b1;
                byte_d       = shift_d;
            end
        end
    end

    // Command FSM: parse opcode/argument bytes, stage in shadows, strobe execute
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        op_sh_d      = op_sh_q;
        data_sh_d    = data_sh_q;
        pend_valid_d = pend_valid_q;
        pend_byte_d  = pend_byte_q;
        op_d         = op_q;
        data_d       = data_q;
        execute_d    = 1'b0;
        data_word    = data_sh_q;

        // A held byte is consumed before a freshly arrived one
        in_valid = pend_valid_q || byte_valid_q;
        in_byte  = pend_valid_q ? pend_byte_q : byte_q;

        // Consuming the pending byte frees the slot, unless a new byte lands now
        if (state_q != EXECUTE && in_valid && pend_valid_q) begin
            pend_valid_d = byte_valid_q;
            pend_byte_d  = byte_q;
        end

        case (state_q)
            READOPCODE: begin
                if (in_valid) begin
                    op_sh_d = in_byte;
                    if (!in_byte[LONG_CMD_BIT]) begin
                        data_sh_d = 32'h0;
                        op_d      = in_byte;
                        data_d    = 32'h0;
                        execute_d = 1'b1;
                        state_d   = EXECUTE;
                    end else begin
                        cnt_d   = 2'd0;
                        state_d = READLONG;
                    end
                end
            end
            READLONG: begin
                if (cs_sync || timeout_fire) begin
                    pend_valid_d = 1'b0;
                    state_d      = READOPCODE;
                end else if (in_valid) begin
                    data_word[{cnt_q, 3'b000} +: 8] = in_byte;
                    data_sh_d = data_word;
                    cnt_d     = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        op_d      = op_sh_q;
                        data_d    = data_word;
                        execute_d = 1'b1;
                        state_d   = EXECUTE;
                    end
                end
            end
            EXECUTE: begin
                state_d = READOPCODE;
                if (byte_valid_q) begin
                    pend_valid_d = 1'b1;
                    pend_byte_d  = byte_q;
                end
            end
            default: begin
                state_d = READOPCODE;
            end
        endcase
    end

    // All receiver state, including registered outputs
    always_ff @(posedge clock or posedge extReset) begin
        if (extReset) begin
            bits_q       <= 3'd0;
            shift_q      <= 8'h00;
            byte_valid_q <= 1'b0;
            byte_q       <= 8'h00;
            state_q      <= READOPCODE;
            cnt_q        <= 2'd0;
            op_sh_q      <= 8'h00;
            data_sh_q    <= 32'h0;
            pend_valid_q <= 1'b0;
            pend_byte_q  <= 8'h00;
            op_q         <= 8'h00;
            data_q       <= 32'h0;
            execute_q    <= 1'b0;
        end else begin
            bits_q       <= bits_d;
            shift_q      <= shift_d;
            byte_valid_q <= byte_valid_d;
            byte_q       <= byte_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            op_sh_q      <= op_sh_d;
            data_sh_q    <= data_sh_d;
            pend_valid_q <= pend_valid_d;
            pend_byte_q  <= pend_byte_d;
            op_q         <= op_d;
            data_q       <= data_d;
            execute_q    <= execute_d;
        end
    end

    assign op      = op_q;
    assign data    = data_q;
    assign execute = execute_q;

endmodule

// File: tb/tb_spi_receiver.sv
// Self-checking bench for spi_receiver: directed SPI byte streams with
// expected commands pushed to a scoreboard queue; a monitor pops and compares
// on every execute strobe. The idle-timeout case is built only when
// SPI_RX_TIMEOUT_EN is defined.
module tb_spi_receiver;

    logic        clock    = 1'b0;
    logic        extReset = 1'b1;
    logic        sclk     = 1'b0;
    logic        cs       = 1'b1;
    logic        rx       = 1'b0;
    logic [7:0]  op;
    logic [31:0] data;
    logic        execute;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [7:0]  op;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    logic prev_exec = 1'b0;

    spi_receiver #(
        .TIMEOUT_W      (20),
        .TIMEOUT_CYCLES (20'd100)
    ) dut (
        .clock    (clock),
        .extReset (extReset),
        .sclk     (sclk),
        .cs       (cs),
        .rx       (rx),
        .op       (op),
        .data     (data),
        .execute  (execute)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive n bits of b, MSB first; rx changes while sclk is low
    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            rx = b[i];
            #40 sclk = 1'b1;
            #40 sclk = 1'b0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_bits(b, 8);
    endtask

    task automatic cs_low();
        cs = 1'b0;
        #40;
    endtask

    task automatic cs_high();
        #40 cs = 1'b1;
        #80;
    endtask

    task automatic expect_cmd(input logic [7:0] o, input logic [31:0] d);
        exp_t e;
        e.op   = o;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Monitor: every execute pulse must match the oldest expected command
    always @(negedge clock) begin
        if (!extReset && execute === 1'b1) begin
            exp_t e;
            check("execute_single_cycle", {31'd0, prev_exec}, 32'd0);
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_execute: got op=0x%02h data=0x%08h, expected no execute at %0t",
                         op, data, $time);
            end else begin
                e = exp_q.pop_front();
                check("cmd_op", {24'd0, op}, {24'd0, e.op});
                check("cmd_data", data, e.data);
            end
        end
        prev_exec = execute;
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clock);
        check("reset_op", {24'd0, op}, 32'h0);
        check("reset_data", data, 32'h0);
        check("reset_execute", {31'd0, execute}, 32'h0);
        @(posedge clock);
        #2 extReset = 1'b0;
        #100;

        // Short command 0x02 with exact latency: send 7 bits, then the last by hand
        cs_low();
        expect_cmd(spi_pkg::OP_QUERY_ID, 32'h0);
        send_bits(8'h02, 7);
        rx = 1'b0;
        #40 sclk = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("latency_edge3_low", {31'd0, execute}, 32'd0);
        @(posedge clock);
        @(negedge clock);
        check("latency_edge4_high", {31'd0, execute}, 32'd1);
        #7 sclk = 1'b0;

        // Long command 0xC0 + 78 56 34 12, cs kept low
        expect_cmd(8'hC0, 32'h12345678);
        send_byte(8'hC0);
        send_byte(8'h78);
        send_byte(8'h56);
        send_byte(8'h34);
        send_byte(8'h12);
        cs_high();

        // Partial byte of 5 bits, then cs high/low and a clean 0x01
        cs_low();
        send_bits(8'hFF, 5);
        cs_high();
        cs_low();
        expect_cmd(8'h01, 32'h0);
        send_byte(8'h01);
        cs_high();

        // Long-command abort: 0x80, AA, BB then cs high
        cs_low();
        send_byte(8'h80);
        send_byte(8'hAA);
        send_byte(8'hBB);
        cs_high();
        #200;
        check("abort_op_held", {24'd0, op}, 32'h01);
        check("abort_data_held", data, 32'h0);
        cs_low();
        expect_cmd(8'h00, 32'h0);
        send_byte(8'h00);
        cs_high();

        // Complete long command, then reset in the middle of the next one
        cs_low();
        expect_cmd(8'hC0, 32'h44332211);
        send_byte(8'hC0);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        #100;
        send_byte(8'hC0);
        send_byte(8'h11);
        extReset = 1'b1;
        cs = 1'b1;
        #20;
        check("midreset_op", {24'd0, op}, 32'h0);
        check("midreset_data", data, 32'h0);
        check("midreset_execute", {31'd0, execute}, 32'h0);
        #40 extReset = 1'b0;
        #60;
        cs_low();
        expect_cmd(8'h02, 32'h0);
        send_byte(8'h02);
        cs_high();

`ifdef SPI_RX_TIMEOUT_EN
        // Idle timeout drops the partial long command 0x81 55
        cs_low();
        send_byte(8'h81);
        send_byte(8'h55);
        #1500;
        expect_cmd(spi_pkg::OP_QUERY_META, 32'h0);
        send_byte(8'h04);
        cs_high();
`endif

        #300;
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
